axi4_rd_sched: RTL and testbench

Round-robin scheduler that shares one AXI4 read-master datapath (req_addr/req_len/req_size/req_valid command side) between NREQ requesters. Each accepted request (start address, byte count up to 4 KiB) is split into AXI4 INCR bursts that never cross a 4 KiB boundary and never exceed MAXBEATS beats. Bursts are issued one at a time, each only after the previous burst's last R beat. The block sits between the DPI-facing request sources and the read master in the PCIe bridge.

---
 rtl/axi4_rd_sched_pkg.sv | 29 ++
 rtl/axi4_rd_sched_rr_arbiter.sv | 29 ++
 rtl/axi4_rd_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_axi4_rd_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_rd_sched_pkg.sv
// axi4_rd_sched_pkg: shared types and helpers for the
// AXI4 read-burst scheduler.
package axi4_rd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    localparam int PAGE_BYTES = 4096;

    // log2 of bytes per beat for a data bus of datw bits
    function automatic int size_log2(input int datw);
        return $clog2(datw / 8);
    endfunction

    // beats left before the next 4 KiB page, for a
    // beat-aligned page offset
    function automatic logic [12:0] beats_to_page(
        input logic [11:0] off,
        input int          sz
    );
        logic [12:0] room;
        room = 13'(PAGE_BYTES) - {1'b0, off};
        return room >> sz;
    endfunction

endpackage

// File: rtl/axi4_rd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: req (request vector), ptr (search start), gnt (one-hot).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // first asserted request at or after ptr, wrapping
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_rd_sched.sv
// axi4_rd_sched: round-robin scheduler splitting requests into
// 4 KiB-safe AXI4 INCR read bursts, one burst outstanding.
// Ports: i_clk, i_rst_n; i_rq_valid/i_rq_addr/i_rq_bytes in,
// o_rq_ready/o_rq_done/o_rq_err out; o_req_addr/len/size/valid
// command out; i_rd_done last-beat pulse in.
// Macro AXI4_RD_SCHED_TIMEOUT_EN enables the WAIT watchdog (TMO).
module axi4_rd_sched
    import axi4_rd_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADRW     = 64,
    parameter int DATW     = 512,
    parameter int MAXBEATS = 64,
    parameter int TMO      = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_rq_valid,
    input  logic [NREQ*ADRW-1:0] i_rq_addr,
    input  logic [NREQ*13-1:0]   i_rq_bytes,
    output logic [NREQ-1:0]      o_rq_ready,
    output logic [NREQ-1:0]      o_rq_done,
    output logic [NREQ-1:0]      o_rq_err,
    output logic [ADRW-1:0]      o_req_addr,
    output logic [7:0]           o_req_len,
    output logic [2:0]           o_req_size,
    output logic                 o_req_valid,
    input  logic                 i_rd_done
);

    localparam int STBW = DATW / 8;
    localparam int SZ   = size_log2(DATW);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [12:0]     MAXB = 13'(MAXBEATS);
    localparam logic [ADRW-1:0] LOW  = ADRW'(STBW - 1);

    state_e            state_q, state_d;
    logic [ADRW-1:0]   addr_q, addr_d;
    logic [12:0]       rem_q, rem_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              vld_q, vld_d;
    logic [ADRW-1:0]   raddr_q, raddr_d;
    logic [7:0]        len_q, len_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rdy;
    logic [PW-1:0]     g_idx;
    logic [ADRW-1:0]   sel_addr;
    logic [12:0]       sel_bytes;

    logic              ld;
    logic [ADRW-1:0]   src_addr;
    logic [12:0]       src_rem;
    logic [12:0]       pg;
    logic [12:0]       beats;
    logic [ADRW-1:0]   step;

`ifdef AXI4_RD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   err_q, err_d;
`else
    localparam bit unused_tmo = (TMO > 0);
`endif

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req (i_rq_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // grants only in IDLE; held low while reset is asserted
    assign rdy = (state_q == ST_IDLE && i_rst_n) ? gnt : '0;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) g_idx = PW'(i);
        end
    end

    assign sel_addr  = i_rq_addr[g_idx*ADRW +: ADRW];
    assign sel_bytes = i_rq_bytes[g_idx*13 +: 13];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        vld_d    = 1'b0;
        raddr_d  = raddr_q;
        len_d    = len_q;
        done_d   = '0;
        ld       = 1'b0;
        src_addr = addr_q;
        src_rem  = rem_q;
        pg       = '0;
        beats    = '0;
        step     = '0;
`ifdef AXI4_RD_SCHED_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|rdy) begin
                    owner_d = g_idx;
                    ptr_d   = (g_idx == PW'(NREQ - 1))
                            ? '0 : g_idx + 1'b1;
                    if (sel_bytes == '0) begin
                        done_d = rdy;
                    end else begin
                        // first burst goes out on the handshake edge
                        ld       = 1'b1;
                        src_addr = sel_addr & ~LOW;
                        src_rem  = 13'(({1'b0, sel_bytes}
                                 + 14'(STBW - 1)) >> SZ);
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef AXI4_RD_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (i_rd_done) begin
                    if (rem_q != '0) begin
                        ld      = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        done_d[owner_q] = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
`ifdef AXI4_RD_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TMO - 1)) begin
                    err_d[owner_q] = 1'b1;
                    rem_d          = '0;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // burst = min(remaining, MAXBEATS, room in page)
        if (ld) begin
            pg    = beats_to_page(src_addr[11:0], SZ);
            beats = src_rem;
            if (pg < beats)   beats = pg;
            if (MAXB < beats) beats = MAXB;
            step    = ADRW'(beats) << SZ;
            vld_d   = 1'b1;
            raddr_d = src_addr;
            len_d   = 8'(beats - 1'b1);
            addr_d  = src_addr + step;
            rem_d   = src_rem - beats;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            raddr_q <= '0;
            len_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            raddr_q <= raddr_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

`ifdef AXI4_RD_SCHED_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_rq_err = err_q;
`else
    assign o_rq_err = '0;
`endif

    assign o_rq_ready  = rdy;
    assign o_rq_done   = done_q;
    assign o_req_addr  = raddr_q;
    assign o_req_len   = len_q;
    assign o_req_size  = 3'(SZ);
    assign o_req_valid = vld_q;

endmodule

// File: tb/tb_axi4_rd_sched.sv
// tb_axi4_rd_sched: randomized + directed bench for axi4_rd_sched
// against a transaction-level model of bursts, grants and dones.
module tb_axi4_rd_sched;

    localparam int NREQ     = 4;
    localparam int ADRW     = 64;
    localparam int DATW     = 512;
    localparam int MAXBEATS = 16;
    localparam int TMO      = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    i_rq_valid;
    logic [255:0]  i_rq_addr;
    logic [51:0]   i_rq_bytes;
    logic [3:0]    o_rq_ready;
    logic [3:0]    o_rq_done;
    logic [3:0]    o_rq_err;
    logic [63:0]   o_req_addr;
    logic [7:0]    o_req_len;
    logic [2:0]    o_req_size;
    logic          o_req_valid;
    logic          i_rd_done;

    axi4_rd_sched #(
        .NREQ     (NREQ),
        .ADRW     (ADRW),
        .DATW     (DATW),
        .MAXBEATS (MAXBEATS),
        .TMO      (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rq_valid  (i_rq_valid),
        .i_rq_addr   (i_rq_addr),
        .i_rq_bytes  (i_rq_bytes),
        .o_rq_ready  (o_rq_ready),
        .o_rq_done   (o_rq_done),
        .o_rq_err    (o_rq_err),
        .o_req_addr  (o_req_addr),
        .o_req_len   (o_req_len),
        .o_req_size  (o_req_size),
        .o_req_valid (o_req_valid),
        .i_rd_done   (i_rd_done)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model state
    bit          busy, outst, hold, rand_on, refill, exp_vld;
    logic [3:0]  exp_done, exp_err, pv;
    logic [63:0] pa [4];
    int          pb [4];
    int          owner, ptr, dly, age;
    logic [63:0] last_addr;
    logic [7:0]  last_len;
    logic [63:0] eq_addr [$];
    logic [7:0]  eq_len  [$];
    logic [63:0] cl_addr [$];
    logic [7:0]  cl_len  [$];
    int          gnt_log [$];
    logic [3:0]  done_log [$];
    logic [3:0]  err_log [$];

    function automatic int rr_pick(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // expected bursts: 64 B beats, stop at 4 KiB page and MAXBEATS
    function automatic void split(logic [63:0] a0, int bytes);
        logic [63:0] a;
        int left, room, b;
        a    = a0 & ~64'h3F;
        left = (bytes + 63) / 64;
        while (left > 0) begin
            room = (4096 - int'(a[11:0])) / 64;
            b    = left;
            if (room < b) b = room;
            if (MAXBEATS < b) b = MAXBEATS;
            eq_addr.push_back(a);
            eq_len.push_back(8'(b - 1));
            a    = a + 64'(b * 64);
            left = left - b;
        end
    endfunction

    function automatic void model_reset();
        busy = 0; outst = 0; hold = 0; exp_vld = 0;
        exp_done = '0; exp_err = '0; pv = '0;
        owner = 0; ptr = 0; dly = 0; age = 0;
        last_addr = '0; last_len = '0;
        eq_addr.delete(); eq_len.delete();
    endfunction

    function automatic logic [63:0] rnd_addr();
        case ($urandom_range(0, 2))
            0: return {$urandom, $urandom};
            1: return 64'hFFFF_FFFF_FFFF_F000
                      | 64'($urandom_range(0, 4095));
            default: return {32'h0, $urandom};
        endcase
    endfunction

    function automatic int rnd_bytes();
        case ($urandom_range(0, 9))
            0: return 0;
            1: return 1;
            2: return 4096;
            default: return $urandom_range(1, 4096);
        endcase
    endfunction

    task automatic post(int r, logic [63:0] a, int b);
        pv[r] = 1'b1;
        pa[r] = a;
        pb[r] = b;
    endtask

    task automatic tick();
        bit issued, last, rd;
        int w;
        logic [3:0] er;
        @(negedge clk);
        exp_err = '0;
`ifdef AXI4_RD_SCHED_TIMEOUT_EN
        if (outst) begin
            age++;
            if (age == TMO + 1) begin
                exp_err = 4'(1 << owner);
                outst = 0; busy = 0; hold = 0;
                eq_addr.delete(); eq_len.delete();
            end
        end
`endif
        check("req_valid", o_req_valid, exp_vld);
        check("rq_done", o_rq_done, exp_done);
        check("rq_err", o_rq_err, exp_err);
        check("req_size", o_req_size, 6);
        issued = 0;
        if (exp_vld && eq_addr.size() > 0) begin
            last_addr = eq_addr.pop_front();
            last_len  = eq_len.pop_front();
            issued    = 1;
        end
        if (o_req_valid) begin
            cl_addr.push_back(o_req_addr);
            cl_len.push_back(o_req_len);
        end
        check("req_addr", o_req_addr, last_addr);
        check("req_len", o_req_len, last_len);
        if (o_rq_done != 0) done_log.push_back(o_rq_done);
        er = o_rq_err;
        if (er != 0) err_log.push_back(er);
        // downstream read master
        exp_vld = 0; exp_done = '0; last = 0; rd = 0;
        if (outst && !hold) begin
            if (dly == 0) begin
                rd = 1; outst = 0;
                if (eq_addr.size() > 0) exp_vld = 1;
                else begin
                    exp_done = 4'(1 << owner);
                    last = 1;
                end
            end else dly--;
        end else if (!busy && rand_on && $urandom_range(0, 7) == 0)
            rd = 1;
        i_rd_done = rd;
        if (issued) begin
            outst = 1; dly = $urandom_range(0, 4); age = 0;
        end
        // requesters
        if (rand_on)
            for (int i = 0; i < 4; i++)
                if (!pv[i] && $urandom_range(0, 3) == 0)
                    post(i, rnd_addr(), rnd_bytes());
        for (int i = 0; i < 4; i++) begin
            i_rq_valid[i]          = pv[i];
            i_rq_addr[i*64 +: 64]  = pa[i];
            i_rq_bytes[i*13 +: 13] = 13'(pb[i]);
        end
        #1;
        w = busy ? -1 : rr_pick(i_rq_valid, ptr);
        check("rq_ready", o_rq_ready, (w < 0) ? 4'b0 : 4'(1 << w));
        if (w >= 0) begin
            gnt_log.push_back(w);
            owner = w;
            ptr   = (w + 1) % 4;
            if (pb[w] == 0) exp_done = 4'(1 << w);
            else begin
                split(pa[w], pb[w]);
                exp_vld = 1;
                busy    = 1;
            end
            if (refill) post(w, rnd_addr(), 64);
            else pv[w] = 1'b0;
        end
        if (last) busy = 0;
    endtask

    task automatic drain(int max);
        int n = 0;
        while ((busy || outst || exp_vld || exp_done != 0
                || pv != 0) && n < max) begin
            tick();
            n++;
        end
        check("drain_idle", {61'b0, busy, outst, pv != 0}, 0);
    endtask

    task automatic run_one(int r, logic [63:0] a, int b);
        cl_addr.delete(); cl_len.delete(); done_log.delete();
        post(r, a, b);
        drain(500);
    endtask

    initial begin
        rst_n = 1'b0;
        i_rq_valid = '0; i_rq_addr = '0; i_rq_bytes = '0;
        i_rd_done = 1'b0;
        rand_on = 0; refill = 0;
        for (int i = 0; i < 4; i++) begin pa[i] = '0; pb[i] = 0; end
        model_reset();

        #3;
        check("rst_valid", o_req_valid, 0);
        check("rst_addr", o_req_addr, 0);
        check("rst_len", o_req_len, 0);
        check("rst_done", o_rq_done, 0);
        check("rst_ready", o_rq_ready, 0);
        check("rst_size", o_req_size, 6);
        @(posedge clk); #2 rst_n = 1'b1;

        run_one(0, 64'h1000, 256);
        check("single_n", cl_addr.size(), 1);
        if (cl_addr.size() == 1) begin
            check("single_addr", cl_addr[0], 64'h1000);
            check("single_len", cl_len[0], 3);
        end
        check("single_done", done_log.size(), 1);

        run_one(0, 64'h0FC0, 128);
        check("cross_n", cl_addr.size(), 2);
        if (cl_addr.size() == 2) begin
            check("cross_a0", cl_addr[0], 64'h0FC0);
            check("cross_l0", cl_len[0], 0);
            check("cross_a1", cl_addr[1], 64'h1000);
            check("cross_l1", cl_len[1], 0);
        end

        run_one(0, 64'h2000, 4096);
        check("max_n", cl_addr.size(), 4);
        for (int i = 0; i < 4 && i < cl_addr.size(); i++) begin
            check("max_addr", cl_addr[i], 64'h2000 + 64'(i * 1024));
            check("max_len", cl_len[i], 15);
        end

        run_one(1, 64'h3000, 0);
        check("zero_n", cl_addr.size(), 0);
        check("zero_done_n", done_log.size(), 1);
        if (done_log.size() == 1)
            check("zero_done", done_log[0], 4'b0010);

        run_one(0, 64'h4000, 1);
        check("one_n", cl_addr.size(), 1);
        if (cl_addr.size() == 1) check("one_len", cl_len[0], 0);

        run_one(0, 64'h1013, 64);
        check("unal_n", cl_addr.size(), 1);
        if (cl_addr.size() == 1) check("unal_addr", cl_addr[0], 64'h1000);

        run_one(3, 64'hFFFF_FFFF_FFFF_FFC0, 128);
        check("wrap_n", cl_addr.size(), 2);
        if (cl_addr.size() == 2) check("wrap_a1", cl_addr[1], 64'h0);

`ifdef AXI4_RD_SCHED_TIMEOUT_EN
        done_log.delete(); err_log.delete();
        hold = 1;
        post(2, 64'h5000, 64);
        for (int n = 0; n < 40 && err_log.size() == 0; n++) tick();
        hold = 0;
        check("tmo_err_n", err_log.size(), 1);
        if (err_log.size() == 1) check("tmo_err", err_log[0], 4'b0100);
        check("tmo_no_done", done_log.size(), 0);
        run_one(1, 64'h6000, 64);
        check("tmo_after_n", cl_addr.size(), 1);
`endif

        // reset while waiting for the last beat
        hold = 1;
        post(0, 64'h7000, 2048);
        for (int n = 0; n < 10 && !outst; n++) tick();
        post(1, 64'h8000, 64);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", o_req_valid, 0);
        check("arst_addr", o_req_addr, 0);
        check("arst_len", o_req_len, 0);
        check("arst_done", o_rq_done, 0);
        check("arst_err", o_rq_err, 0);
        check("arst_ready", o_rq_ready, 0);
        model_reset();
        i_rq_valid = '0;
        i_rd_done  = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        // fairness with every requester continuously valid
        gnt_log.delete();
        refill = 1;
        for (int i = 0; i < 4; i++) post(i, rnd_addr(), 64);
        for (int n = 0; n < 400 && gnt_log.size() < 5; n++) tick();
        refill = 0;
        check("fair_n", gnt_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++)
            check("fair_order", gnt_log[i], i % 4);
        drain(2000);

        rand_on = 1;
        repeat (3000) tick();
        rand_on = 0;
        drain(30000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
